// File: rtl/cascade_pkg.sv
// Shared types and constants for the detection-pipeline window scheduler.
package cascade_pkg;

    localparam int PKG_IMG_W     = 45;
    localparam int PKG_IMG_H     = 45;
    localparam int PKG_SCALE_NUM = 2;

    localparam int W_X = $clog2(PKG_IMG_W);
    localparam int W_Y = $clog2(PKG_IMG_H);
    localparam int W_S = (PKG_SCALE_NUM > 1) ? $clog2(PKG_SCALE_NUM) : 1;

    typedef struct packed {
        logic [W_X-1:0] x;
        logic [W_Y-1:0] y;
        logic [W_S-1:0] scale;
    } job_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} sched_state_e;

    // dim * 4^s / 5^s with a single final integer division
    function automatic int scaled_dim(input int dim, input int s);
        int num;
        int den;
        num = dim;
        den = 1;
        for (int i = 0; i < s; i++) begin
            num = num * 4;
            den = den * 5;
        end
        return num / den;
    endfunction

    localparam int SCALED_W [PKG_SCALE_NUM] = '{scaled_dim(PKG_IMG_W, 0), scaled_dim(PKG_IMG_W, 1)};
    localparam int SCALED_H [PKG_SCALE_NUM] = '{scaled_dim(PKG_IMG_H, 0), scaled_dim(PKG_IMG_H, 1)};

endpackage

// File: rtl/window_scheduler_fifo.sv
// Synchronous in-flight job FIFO; the storage array is not reset, only the pointers and count.
module inflight_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/window_scheduler.sv
// Issues every (x, y, scale) window job in order and pairs each with its in-order classifier result.
module window_scheduler
    import cascade_pkg::*;
#(
    parameter int IMG_WIDTH      = 45,
    parameter int IMG_HEIGHT     = 45,
    parameter int FEATURE_WIDTH  = 25,
    parameter int FEATURE_HEIGHT = 25,
    parameter int SCALE_NUM      = 2,
    parameter int STEP           = 1,
    parameter int MAX_INFLIGHT   = 4,
    parameter int W_CNT          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             job_valid,
    input  logic             job_ready,
    output job_t             job_data,
    input  logic             result_valid,
    output logic             result_ready,
    input  logic             result_data,
    output logic             det_valid,
    input  logic             det_ready,
    output job_t             det_data,
    output logic [W_CNT-1:0] det_count,
    output logic             err_orphan
);
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    sched_state_e   state, state_n;
    logic [W_X-1:0] x, x_n;
    logic [W_Y-1:0] y, y_n;
    logic [W_S-1:0] s, s_n;
    logic           armed;
    logic           scale_ok [SCALE_NUM];
    logic [W_X-1:0] x_last   [SCALE_NUM];
    logic [W_Y-1:0] y_last   [SCALE_NUM];

    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  inflight;
    job_t           fifo_head;
    logic           job_hs, res_hs, pop, start_ok, last_scale, x_wrap, y_wrap;

    for (genvar g = 0; g < SCALE_NUM; g++) begin : g_scale
        localparam int SW = scaled_dim(IMG_WIDTH, g);
        localparam int SH = scaled_dim(IMG_HEIGHT, g);
        localparam bit OK = (SW >= FEATURE_WIDTH) && (SH >= FEATURE_HEIGHT);
        localparam int XL = OK ? SW - FEATURE_WIDTH : 0;
        localparam int YL = OK ? SH - FEATURE_HEIGHT : 0;
        assign scale_ok[g] = OK;
        assign x_last[g]   = W_X'(XL);
        assign y_last[g]   = W_Y'(YL);
    end

    assign job_data     = '{x: x, y: y, scale: s};
    assign job_hs       = job_valid && job_ready;
    assign result_ready = fifo_empty || !det_valid || det_ready;
    assign res_hs       = result_valid && result_ready;
    assign pop          = res_hs && !fifo_empty;
    assign start_ok     = (state == IDLE) && start;
    assign busy         = (state == ISSUE) || (state == DRAIN);
    assign last_scale   = (int'(s) == SCALE_NUM - 1);
    assign x_wrap       = (int'(x) + STEP) > int'(x_last[s]);
    assign y_wrap       = (int'(y) + STEP) > int'(y_last[s]);

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        s_n       = s;
        job_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ISSUE;
                    x_n     = '0;
                    y_n     = '0;
                    s_n     = '0;
                end
            end
            ISSUE: begin
                if (!scale_ok[s]) begin
                    x_n = '0;
                    y_n = '0;
                    if (last_scale) state_n = DRAIN;
                    else            s_n     = s + W_S'(1);
                end else begin
                    // armed delays the first offer by one cycle after entering ISSUE
                    job_valid = armed && !fifo_full;
                    if (job_hs) begin
                        if (!x_wrap) begin
                            x_n = x + W_X'(STEP);
                        end else begin
                            x_n = '0;
                            if (!y_wrap) begin
                                y_n = y + W_Y'(STEP);
                            end else begin
                                y_n = '0;
                                if (last_scale) state_n = DRAIN;
                                else            s_n     = s + W_S'(1);
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if ((inflight == '0) && !det_valid) state_n = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            s     <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            s     <= s_n;
            armed <= (state == ISSUE);
        end
    end

    // A result arriving with nothing in flight is consumed and flagged, never paired.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_valid  <= 1'b0;
            det_data   <= '0;
            det_count  <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (start_ok) begin
                det_count  <= '0;
                err_orphan <= 1'b0;
            end
            if (pop && result_data) begin
                det_valid <= 1'b1;
                det_data  <= fifo_head;
                if (det_count != '1) det_count <= det_count + 1'b1;
            end else if (det_ready) begin
                det_valid <= 1'b0;
            end
            if (res_hs && fifo_empty) err_orphan <= 1'b1;
        end
    end

    inflight_fifo #(
        .W     ($bits(job_t)),
        .DEPTH (MAX_INFLIGHT)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (job_hs),
        .wdata (job_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (inflight)
    );

endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: a default 45x45 instance and a 27x27 instance.
module tb_window_scheduler;
    import cascade_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, job_ready = 1'b0, result_valid = 1'b0;
    logic        result_data = 1'b0, det_ready = 1'b1;
    logic        busy, done, job_valid, result_ready, det_valid, err_orphan;
    job_t        job_data, det_data;
    logic [15:0] det_count;

    logic        s_start = 1'b0, s_job_ready = 1'b0, s_result_valid = 1'b0;
    logic        s_busy, s_done, s_job_valid, s_result_ready, s_det_valid, s_err_orphan;
    job_t        s_job_data, s_det_data;
    logic [15:0] s_det_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    job_t exp_jobs[$];
    job_t inflight_m[$];
    job_t exp_dets[$];

    window_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .det_valid(det_valid), .det_ready(det_ready), .det_data(det_data),
        .det_count(det_count), .err_orphan(err_orphan)
    );

    window_scheduler #(.IMG_WIDTH(27), .IMG_HEIGHT(27)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .job_valid(s_job_valid), .job_ready(s_job_ready), .job_data(s_job_data),
        .result_valid(s_result_valid), .result_ready(s_result_ready), .result_data(1'b0),
        .det_valid(s_det_valid), .det_ready(1'b1), .det_data(s_det_data),
        .det_count(s_det_count), .err_orphan(s_err_orphan)
    );

    // Reference job order: scale-major, then row-major, stride 1, 25x25 window.
    task automatic gen_frame(input int iw, input int ih);
        exp_jobs.delete();
        inflight_m.delete();
        exp_dets.delete();
        for (int sc = 0; sc < 2; sc++) begin
            int   sw;
            int   sh;
            job_t j;
            sw = (sc == 0) ? iw : (iw * 4) / 5;
            sh = (sc == 0) ? ih : (ih * 4) / 5;
            if (sw >= 25 && sh >= 25)
                for (int yy = 0; yy <= sh - 25; yy++)
                    for (int xx = 0; xx <= sw - 25; xx++) begin
                        j.x     = W_X'(xx);
                        j.y     = W_Y'(yy);
                        j.scale = W_S'(sc);
                        exp_jobs.push_back(j);
                    end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        job_ready = 1'b0; result_valid = 1'b0; result_data = 1'b0; det_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (job_valid !== 1'b0) begin n_fail++; $display("FAIL reset_job_valid: got %b expected 0", job_valid); end
        n_checks++; if (det_valid !== 1'b0) begin n_fail++; $display("FAIL reset_det_valid: got %b expected 0", det_valid); end
        n_checks++; if (det_count !== 16'd0) begin n_fail++; $display("FAIL reset_det_count: got %0d expected 0", det_count); end
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
        n_checks++; if (job_data !== '0) begin n_fail++; $display("FAIL reset_job_data: got %h expected 0", job_data); end
        n_checks++; if (det_data !== '0) begin n_fail++; $display("FAIL reset_det_data: got %h expected 0", det_data); end
        // Empty FIFO: results are accepted (and dropped) even when idle
        n_checks++; if (result_ready !== 1'b1) begin n_fail++; $display("FAIL reset_result_ready: got %b expected 1", result_ready); end
    endtask

    task automatic test_full_frame();
        int   njobs = 0;
        int   ndone = 0;
        int   cyc   = 0;
        job_t e;
        gen_frame(45, 45);
        job_ready = 1'b1; result_valid = 1'b1; result_data = 1'b0; det_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", busy); end
        n_checks++; if (job_valid !== 1'b0) begin n_fail++; $display("FAIL latency_cycle1: got %b expected 0", job_valid); end
        while (ndone == 0 && cyc < 2000) begin
            @(negedge clk); #1;
            if (cyc == 0) begin
                n_checks++; if (job_valid !== 1'b1) begin n_fail++; $display("FAIL latency_cycle2: got %b expected 1", job_valid); end
            end
            if (result_valid && result_ready && inflight_m.size() > 0) void'(inflight_m.pop_front());
            if (job_valid && job_ready) begin
                njobs++;
                if (exp_jobs.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL full_extra_job: got %h expected none", job_data);
                end else begin
                    e = exp_jobs.pop_front();
                    n_checks++; if (job_data !== e) begin n_fail++; $display("FAIL full_job_data: got %h expected %h", job_data, e); end
                    inflight_m.push_back(e);
                end
            end
            if (done) ndone++;
            cyc++;
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (done) ndone++;
        end
        n_checks++; if (njobs != 585) begin n_fail++; $display("FAIL full_job_count: got %0d expected 585", njobs); end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", ndone); end
        n_checks++; if (det_count !== 16'd0) begin n_fail++; $display("FAIL full_det_count: got %0d expected 0", det_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_small_image();
        int   njobs = 0;
        int   ndone = 0;
        int   cyc   = 0;
        job_t e;
        gen_frame(27, 27);
        s_job_ready = 1'b1; s_result_valid = 1'b1;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        while (ndone == 0 && cyc < 200) begin
            @(negedge clk); #1;
            if (s_result_valid && s_result_ready && inflight_m.size() > 0) void'(inflight_m.pop_front());
            if (s_job_valid && s_job_ready) begin
                njobs++;
                if (exp_jobs.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL small_extra_job: got %h expected none", s_job_data);
                end else begin
                    e = exp_jobs.pop_front();
                    n_checks++; if (s_job_data !== e) begin n_fail++; $display("FAIL small_job_data: got %h expected %h", s_job_data, e); end
                    inflight_m.push_back(e);
                end
            end
            if (s_done) ndone++;
            cyc++;
        end
        n_checks++; if (njobs != 9) begin n_fail++; $display("FAIL small_job_count: got %0d expected 9", njobs); end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL small_done: got %0d expected 1", ndone); end
        s_result_valid = 1'b0; s_job_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int   nj = 0;
        job_t e;
        do_reset();
        gen_frame(45, 45);
        job_ready = 1'b1; result_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) begin
            @(negedge clk); #1;
            if (job_valid && job_ready) begin
                nj++;
                e = exp_jobs.pop_front();
                n_checks++; if (job_data !== e) begin n_fail++; $display("FAIL bp_job_data: got %h expected %h", job_data, e); end
                inflight_m.push_back(e);
            end
        end
        n_checks++; if (nj != 4) begin n_fail++; $display("FAIL bp_inflight_cap: got %0d expected 4", nj); end
        n_checks++; if (job_valid !== 1'b0) begin n_fail++; $display("FAIL bp_job_valid_low: got %b expected 0", job_valid); end
        @(negedge clk); result_valid = 1'b1; #1;
        n_checks++; if (result_ready !== 1'b1) begin n_fail++; $display("FAIL bp_result_ready: got %b expected 1", result_ready); end
        nj = 0;
        repeat (10) begin
            @(negedge clk); result_valid = 1'b0; #1;
            if (job_valid && job_ready) begin
                nj++;
                e = exp_jobs.pop_front();
                n_checks++; if (job_data !== e) begin n_fail++; $display("FAIL bp_next_job: got %h expected %h", job_data, e); end
            end
        end
        n_checks++; if (nj != 1) begin n_fail++; $display("FAIL bp_release_one: got %0d expected 1", nj); end
        n_checks++; if (job_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_again: got %b expected 0", job_valid); end
    endtask

    task automatic test_det_hold();
        int   seen = 0;
        int   cyc  = 0;
        job_t e;
        job_t tgt;
        tgt.x = W_X'(3); tgt.y = '0; tgt.scale = '0;
        do_reset();
        gen_frame(45, 45);
        job_ready = 1'b1; result_valid = 1'b1; det_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (seen == 0 && cyc < 60) begin
            @(negedge clk);
            result_data = (inflight_m.size() > 0) && (inflight_m[0] == tgt);
            #1;
            if (result_valid && result_ready && inflight_m.size() > 0) begin
                e = inflight_m.pop_front();
                if (result_data) exp_dets.push_back(e);
            end
            if (job_valid && job_ready) begin
                e = exp_jobs.pop_front();
                n_checks++; if (job_data !== e) begin n_fail++; $display("FAIL det_job_data: got %h expected %h", job_data, e); end
                inflight_m.push_back(e);
            end
            if (det_valid) seen = 1;
            cyc++;
        end
        n_checks++; if (seen != 1 || exp_dets.size() != 1) begin n_fail++; $display("FAIL det_appear: got seen=%0d dets=%0d expected 1 1", seen, exp_dets.size()); end
        if (exp_dets.size() == 0) exp_dets.push_back(tgt);
        repeat (5) begin
            @(negedge clk); result_data = 1'b0; #1;
            n_checks++; if (det_valid !== 1'b1 || det_data !== tgt) begin n_fail++; $display("FAIL det_hold: got v=%b d=%h expected v=1 d=%h", det_valid, det_data, tgt); end
            n_checks++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL det_stall_ready: got %b expected 0", result_ready); end
            n_checks++; if (det_count !== 16'd1) begin n_fail++; $display("FAIL det_count: got %0d expected 1", det_count); end
            if (job_valid && job_ready) begin
                e = exp_jobs.pop_front();
                inflight_m.push_back(e);
            end
        end
        @(negedge clk); det_ready = 1'b1; #1;
        e = exp_dets.pop_front();
        n_checks++; if (!(det_valid && det_ready) || det_data !== e) begin n_fail++; $display("FAIL det_take: got v=%b d=%h expected v=1 d=%h", det_valid, det_data, e); end
    endtask

    task automatic test_orphan();
        do_reset();
        #1;
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear_rst: got %b expected 0", err_orphan); end
        @(negedge clk); result_valid = 1'b1;
        @(negedge clk); result_valid = 1'b0; #1;
        n_checks++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_set: got %b expected 1", err_orphan); end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear_start: got %b expected 0", err_orphan); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL orphan_busy: got %b expected 1", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int   nj  = 0;
        int   cyc = 0;
        job_t e;
        do_reset();
        gen_frame(45, 45);
        job_ready = 1'b1; result_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (nj < 3 && cyc < 20) begin
            @(negedge clk); #1;
            if (job_valid && job_ready) begin
                nj++;
                e = exp_jobs.pop_front();
                n_checks++; if (job_data !== e) begin n_fail++; $display("FAIL mid_job_data: got %h expected %h", job_data, e); end
            end
            cyc++;
        end
        n_checks++; if (nj != 3) begin n_fail++; $display("FAIL mid_three_jobs: got %0d expected 3", nj); end
        @(negedge clk); job_ready = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if ({busy, done, job_valid, det_valid, err_orphan} !== 5'b0) begin n_fail++; $display("FAIL mid_rst_flags: got %b expected 00000", {busy, done, job_valid, det_valid, err_orphan}); end
        n_checks++; if (job_data !== '0 || det_data !== '0 || det_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_data: got %h %h %0d expected 0 0 0", job_data, det_data, det_count); end
        gen_frame(45, 45);
        job_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nj = 0; cyc = 0;
        while (nj == 0 && cyc < 10) begin
            @(negedge clk); #1;
            if (job_valid && job_ready) begin
                nj++;
                e = exp_jobs.pop_front();
                n_checks++; if (job_data !== e) begin n_fail++; $display("FAIL mid_restart_job: got %h expected %h", job_data, e); end
            end
            cyc++;
        end
        n_checks++; if (nj != 1) begin n_fail++; $display("FAIL mid_restart_timeout: got %0d expected 1", nj); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_small_image();
        test_backpressure();
        test_det_hold();
        test_orphan();
        test_reset_mid_frame();
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
